// File: rtl/sm2201_bridge_pkg.sv
// Shared types and constants for the sm2201 ISA-to-CAMAC bridge.
// Holds the FSM state encoding, status-byte bit positions and lane sizing.
package sm2201_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_RELEASE
   } state_e;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_TIMEOUT = 1;
   localparam int STAT_LAM     = 2;
   localparam int STAT_IRQ_EN  = 3;

   // Number of address bits that select a byte lane within one CAMAC word.
   function automatic int lane_bits(input int data_w);
      return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
   endfunction

endpackage

// File: rtl/sm2201_sync2.sv
// Two-flop synchroniser for asynchronous ISA strobes and CAMAC status lines.
// Resets to RST_VAL so idle-high lines do not produce a false edge after reset.
module sm2201_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= {2{RST_VAL}};
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/sm2201_isa_camac_bridge.sv
// ISA I/O window to CAMAC bridge: byte lanes assemble into a shadow word,
// lane 0 triggers the CAMAC cycle and the ISA cycle is stretched via CHRDY.
module sm2201_isa_camac_bridge
   import sm2201_bridge_pkg::*;
#(
   parameter logic [9:0] BASE_ADDR      = 10'h100,
   parameter int         SPAN_LOG2      = 6,
   parameter int         CB_DATA_W      = 16,
   parameter int         WAIT_CYCLES    = 4,
   parameter int         TIMEOUT_CYCLES = 64,
   localparam int        LANES          = CB_DATA_W / 8,
   localparam int        LANE_BITS      = lane_bits(CB_DATA_W),
   localparam int        SUB_W          = SPAN_LOG2 - LANE_BITS
) (
   input  logic                 isa_clk,
   input  logic                 isa_reset,
   input  logic [9:0]           isa_addr,
   input  logic                 isa_aen,
   input  logic                 isa_ior,
   input  logic                 isa_iow,
   input  logic [7:0]           isa_data_in,
   output logic [7:0]           isa_data_out,
   output logic                 isa_data_oe,
   output logic                 isa_chrdy,
   output logic                 isa_irq,
   output logic [SUB_W-1:0]     cb_addr,
   output logic                 cb_write,
   output logic [CB_DATA_W-1:0] cb_data_out,
   output logic                 cb_data_oe,
   input  logic [CB_DATA_W-1:0] cb_data_in,
   output logic                 cb_cx1,
   input  logic                 cb_prr,
   input  logic                 cb_zk4
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic ior_s, iow_s, prr_s, zk4_s;

   sm2201_sync2 #(.RST_VAL(1'b1)) u_sync_ior (.clk_i(isa_clk), .rst_i(isa_reset), .d_i(isa_ior), .q_o(ior_s));
   sm2201_sync2 #(.RST_VAL(1'b1)) u_sync_iow (.clk_i(isa_clk), .rst_i(isa_reset), .d_i(isa_iow), .q_o(iow_s));
   sm2201_sync2 #(.RST_VAL(1'b1)) u_sync_prr (.clk_i(isa_clk), .rst_i(isa_reset), .d_i(cb_prr),  .q_o(prr_s));
   sm2201_sync2 #(.RST_VAL(1'b1)) u_sync_zk4 (.clk_i(isa_clk), .rst_i(isa_reset), .d_i(cb_zk4),  .q_o(zk4_s));

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CB_DATA_W-1:0]   shadow_q, shadow_d;
   logic                   timeout_q, timeout_d;
   logic                   irq_en_q, irq_en_d;
   logic [SUB_W-1:0]       cb_addr_q, cb_addr_d;
   logic                   cb_write_q, cb_write_d;
   logic [CB_DATA_W-1:0]   cb_data_out_q, cb_data_out_d;
   logic                   cb_data_oe_q, cb_data_oe_d;
   logic                   ior_p_q, iow_p_q;

   logic [SPAN_LOG2-1:0]   offset;
   logic [LANE_BITS-1:0]   lane;
   logic [SUB_W-1:0]       sub;
   logic                   sel, is_status, start_rd, start_wr, done, busy;
   logic [7:0]             status_byte, rd_byte;

   assign offset    = isa_addr[SPAN_LOG2-1:0];
   assign lane      = offset[LANE_BITS-1:0];
   assign sub       = offset[SPAN_LOG2-1:LANE_BITS];
   assign sel       = !isa_aen && (isa_addr[9:SPAN_LOG2] == BASE_ADDR[9:SPAN_LOG2]);
   assign is_status = &offset;
   assign start_rd  = ior_p_q && !ior_s;
   assign start_wr  = iow_p_q && !iow_s;
   assign done      = (state_q == ST_HOLD) || (state_q == ST_RELEASE);
   assign busy      = (state_q != ST_IDLE);

   always_ff @(posedge isa_clk or posedge isa_reset) begin
      if (isa_reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         shadow_q      <= '0;
         timeout_q     <= 1'b0;
         irq_en_q      <= 1'b0;
         cb_addr_q     <= '0;
         cb_write_q    <= 1'b0;
         cb_data_out_q <= '0;
         cb_data_oe_q  <= 1'b0;
         ior_p_q       <= 1'b1;
         iow_p_q       <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shadow_q      <= shadow_d;
         timeout_q     <= timeout_d;
         irq_en_q      <= irq_en_d;
         cb_addr_q     <= cb_addr_d;
         cb_write_q    <= cb_write_d;
         cb_data_out_q <= cb_data_out_d;
         cb_data_oe_q  <= cb_data_oe_d;
         ior_p_q       <= ior_s;
         iow_p_q       <= iow_s;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      shadow_d      = shadow_q;
      timeout_d     = timeout_q;
      irq_en_d      = irq_en_q;
      cb_addr_d     = cb_addr_q;
      cb_write_d    = cb_write_q;
      cb_data_out_d = cb_data_out_q;
      cb_data_oe_d  = cb_data_oe_q;
      case (state_q)
         ST_IDLE: begin
            if (sel && (start_rd || start_wr)) begin
               if (is_status) begin
                  if (start_wr) begin
                     irq_en_d = isa_data_in[STAT_IRQ_EN];
                     if (isa_data_in[STAT_TIMEOUT]) timeout_d = 1'b0;
                  end
               end else if (lane == '0) begin
                  // Lane 0 commits the staged upper lanes together with this byte.
                  state_d      = ST_SETUP;
                  cb_addr_d    = sub;
                  cb_write_d   = start_wr;
                  cb_data_oe_d = start_wr;
                  if (start_wr) begin
                     shadow_d[7:0] = isa_data_in;
                     cb_data_out_d = {shadow_q[CB_DATA_W-1:8], isa_data_in};
                  end
               end else if (start_wr) begin
                  for (int k = 1; k < LANES; k++) begin
                     if (int'(lane) == k) shadow_d[8*k +: 8] = isa_data_in;
                  end
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
            cnt_d   = CNT_W'(1);
         end
         ST_STROBE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q >= CNT_W'(WAIT_CYCLES) && !prr_s) begin
               state_d = ST_HOLD;
               if (!cb_write_q) shadow_d = cb_data_in;
            end else if (cnt_q >= CNT_W'(TIMEOUT_CYCLES)) begin
               state_d   = ST_HOLD;
               timeout_d = 1'b1;
               shadow_d  = '1;
            end
         end
         ST_HOLD: begin
            state_d      = ST_RELEASE;
            cb_data_oe_d = 1'b0;
         end
         ST_RELEASE: begin
            if (ior_s && iow_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign status_byte = {4'b0000, irq_en_q, !zk4_s, timeout_q, busy};

   always_comb begin
      rd_byte = 8'h00;
      if (is_status) begin
         rd_byte = status_byte;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            if (int'(lane) == k) rd_byte = shadow_q[8*k +: 8];
         end
      end
   end

   // CHRDY follows the raw strobe so the stretch begins before synchronisation.
   assign isa_chrdy    = isa_reset ||
                         !(sel && (!isa_ior || !isa_iow) && (lane == '0) && !is_status && !done);
   assign isa_data_oe  = !isa_reset && sel && !isa_ior;
   assign isa_data_out = isa_data_oe ? rd_byte : 8'h00;
   assign isa_irq      = irq_en_q && !zk4_s;
   assign cb_addr      = cb_addr_q;
   assign cb_write     = cb_write_q;
   assign cb_data_out  = cb_data_out_q;
   assign cb_data_oe   = cb_data_oe_q;
   assign cb_cx1       = (state_q != ST_STROBE);

endmodule

// File: tb/tb_sm2201_isa_camac_bridge.sv
// Bench for the sm2201 ISA-to-CAMAC bridge: directed scenarios followed by
// randomized ISA traffic against a byte-array model of the bridge registers.
module tb_sm2201_isa_camac_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  addr = 10'h000;
   logic        aen = 1'b0;
   logic        ior = 1'b1;
   logic        iow = 1'b1;
   logic [7:0]  din = 8'h00;
   logic [7:0]  dout;
   logic        doe, chrdy, irq;
   logic [4:0]  cb_addr;
   logic        cb_write, cb_doe, cx1;
   logic [15:0] cb_dout;
   logic [15:0] cb_din = 16'h0000;
   logic        prr = 1'b1;
   logic        zk4 = 1'b1;

   sm2201_isa_camac_bridge dut (
      .isa_clk(clk), .isa_reset(rst), .isa_addr(addr), .isa_aen(aen),
      .isa_ior(ior), .isa_iow(iow), .isa_data_in(din), .isa_data_out(dout),
      .isa_data_oe(doe), .isa_chrdy(chrdy), .isa_irq(irq),
      .cb_addr(cb_addr), .cb_write(cb_write), .cb_data_out(cb_dout),
      .cb_data_oe(cb_doe), .cb_data_in(cb_din), .cb_cx1(cx1),
      .cb_prr(prr), .cb_zk4(zk4)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // CAMAC slave: counts cx1 pulses, captures the cycle, answers with prr.
   int          pulses = 0;
   int          cur_len = 0;
   int          last_len = 0;
   int          prr_delay = 5;
   bit          prr_static = 0;
   logic [4:0]  cap_addr;
   logic        cap_write, cap_doe;
   logic [15:0] cap_data;

   initial begin
      forever begin
         @(negedge clk);
         if (!cx1) begin
            if (cur_len == 0) begin
               pulses++;
               cap_addr  = cb_addr;
               cap_write = cb_write;
               cap_doe   = cb_doe;
               cap_data  = cb_dout;
            end
            cur_len++;
         end else if (cur_len != 0) begin
            last_len = cur_len;
            cur_len  = 0;
         end
         prr = !(prr_static || (!cx1 && cur_len > prr_delay));
      end
   end

   logic [7:0] rd_val;
   int         stretch;
   bit         saw_oe;

   task automatic isa_cycle(input logic [9:0] a, input bit wr, input logic [7:0] d, input bit dma);
      int n;
      @(negedge clk);
      addr = a; aen = dma; din = d;
      if (wr) iow = 1'b0; else ior = 1'b0;
      stretch = 0; saw_oe = 0; n = 0;
      while (1) begin
         @(negedge clk);
         n++;
         if (doe) saw_oe = 1;
         if (!chrdy) stretch++;
         else if (n >= 4) break;
         if (n >= 300) begin
            check_val("chrdy_bound", 32'(n), 32'(0));
            break;
         end
      end
      rd_val = dout;
      @(negedge clk);
      ior = 1'b1; iow = 1'b1; aen = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   logic [7:0] m_sh [2];
   bit         m_to, m_irqen;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pb;
      cb_din = 16'hA55A;
      repeat (3) @(negedge clk);
      check_val("rst_cx1", cx1, 1);
      check_val("rst_chrdy", chrdy, 1);
      check_val("rst_irq", irq, 0);
      check_val("rst_doe", doe, 0);
      check_val("rst_dout", dout, 0);
      check_val("rst_cb_addr", cb_addr, 0);
      check_val("rst_cb_write", cb_write, 0);
      check_val("rst_cb_doe", cb_doe, 0);
      check_val("rst_cb_dout", cb_dout, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Lane 0 read through CAMAC, then lane 1 from the shadow.
      pb = pulses; prr_delay = 5;
      isa_cycle(10'h104, 0, 8'h00, 0);
      check_val("rd0_data", rd_val, 8'h5A);
      check_val("rd0_pulse", 32'(pulses - pb), 1);
      check_val("rd0_addr", cap_addr, 2);
      check_val("rd0_write", cap_write, 0);
      check_val("rd0_stretch", 32'(stretch > 0), 1);
      pb = pulses;
      isa_cycle(10'h105, 0, 8'h00, 0);
      check_val("rd1_data", rd_val, 8'hA5);
      check_val("rd1_pulse", 32'(pulses - pb), 0);
      check_val("rd1_stretch", 32'(stretch), 0);

      // Staged write of a full word.
      pb = pulses;
      isa_cycle(10'h107, 1, 8'h12, 0);
      check_val("wr1_pulse", 32'(pulses - pb), 0);
      isa_cycle(10'h106, 1, 8'h34, 0);
      check_val("wr0_pulse", 32'(pulses - pb), 1);
      check_val("wr0_addr", cap_addr, 3);
      check_val("wr0_write", cap_write, 1);
      check_val("wr0_data", cap_data, 16'h1234);
      check_val("wr0_doe", cap_doe, 1);

      // Response already present: strobe is exactly the minimum width.
      prr_static = 1;
      repeat (4) @(negedge clk);
      isa_cycle(10'h102, 0, 8'h00, 0);
      check_val("min_width", 32'(last_len), 4);
      check_val("min_data", rd_val, 8'h5A);
      prr_static = 0;
      repeat (4) @(negedge clk);

      // Timeout path.
      prr_delay = 255;
      isa_cycle(10'h100, 0, 8'h00, 0);
      check_val("to_width", 32'(last_len), 64);
      check_val("to_data", rd_val, 8'hFF);
      isa_cycle(10'h13F, 0, 8'h00, 0);
      check_val("to_status", rd_val, 8'h02);
      isa_cycle(10'h13F, 1, 8'h02, 0);
      isa_cycle(10'h13F, 0, 8'h00, 0);
      check_val("to_cleared", rd_val, 8'h00);
      prr_delay = 5;

      // Accesses the bridge must ignore.
      pb = pulses;
      isa_cycle(10'h104, 0, 8'h00, 1);
      check_val("dma_oe", saw_oe, 0);
      check_val("dma_stretch", 32'(stretch), 0);
      isa_cycle(10'h140, 0, 8'h00, 0);
      check_val("out_oe", saw_oe, 0);
      check_val("out_stretch", 32'(stretch), 0);
      check_val("ign_pulse", 32'(pulses - pb), 0);

      // LAM interrupt masking.
      zk4 = 1'b0;
      repeat (4) @(negedge clk);
      check_val("irq_masked", irq, 0);
      isa_cycle(10'h13F, 1, 8'h08, 0);
      check_val("irq_on", irq, 1);
      isa_cycle(10'h13F, 0, 8'h00, 0);
      check_val("irq_status", rd_val, 8'h0C);
      zk4 = 1'b1;
      repeat (3) @(negedge clk);
      check_val("irq_off", irq, 0);

      // Reset in the middle of a CAMAC strobe.
      zk4 = 1'b0;
      prr_delay = 255;
      @(negedge clk);
      addr = 10'h100; ior = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (!cx1) break;
      end
      check_val("strobe_reached", cx1, 0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("mid_rst_cx1", cx1, 1);
      check_val("mid_rst_chrdy", chrdy, 1);
      check_val("mid_rst_irq", irq, 0);
      @(negedge clk);
      ior = 1'b1; zk4 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      isa_cycle(10'h13F, 0, 8'h00, 0);
      check_val("post_rst_status", rd_val, 8'h00);

      // Randomized traffic against the register model.
      m_sh[0] = 8'h00; m_sh[1] = 8'h00; m_to = 0; m_irqen = 0;
      for (int i = 0; i < 60; i++) begin
         logic [9:0] a;
         logic [5:0] off;
         logic [7:0] d;
         bit         wr;
         off       = 6'($urandom_range(0, 63));
         a         = 10'h100 + 10'(off);
         wr        = 1'($urandom_range(0, 1));
         d         = 8'($urandom);
         prr_delay = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 20));
         cb_din    = 16'($urandom);
         pb        = pulses;
         isa_cycle(a, wr, d, 0);
         if (off == 6'd63) begin
            if (wr) begin
               m_irqen = d[3];
               if (d[1]) m_to = 0;
            end else begin
               check_val("rnd_status", rd_val, {4'b0000, m_irqen, 1'b0, m_to, 1'b0});
            end
            check_val("rnd_stat_pulse", 32'(pulses - pb), 0);
         end else if (off[0]) begin
            if (wr) m_sh[1] = d;
            else check_val("rnd_rd1", rd_val, m_sh[1]);
            check_val("rnd_lane1_pulse", 32'(pulses - pb), 0);
         end else begin
            check_val("rnd_pulse", 32'(pulses - pb), 1);
            check_val("rnd_addr", cap_addr, 5'(off >> 1));
            check_val("rnd_write", cap_write, wr);
            if (wr) begin
               m_sh[0] = d;
               check_val("rnd_wdata", cap_data, {m_sh[1], m_sh[0]});
            end
            if (prr_delay == 255) begin
               m_to = 1;
               m_sh[0] = 8'hFF; m_sh[1] = 8'hFF;
               check_val("rnd_to_width", 32'(last_len), 64);
            end else if (!wr) begin
               m_sh[0] = cb_din[7:0]; m_sh[1] = cb_din[15:8];
            end
            if (!wr) check_val("rnd_rd0", rd_val, m_sh[0]);
         end
         check_val("rnd_irq", irq, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
